axi_simpleuart_bridge: RTL and testbench

AXI4-Lite slave that exposes the simpleuart register interface (clock divider and data registers) on the SoC interconnect. It sits directly upstream of simpleuart: it consumes AXI4-Lite transactions from the interconnect/CPU side and drives simpleuart's `reg_div_*` / `reg_dat_*` strobes, including back-pressure from `reg_dat_wait`. It handles one transaction at a time, with a wait-state timeout, and returns SLVERR for unmapped offsets.

---
 rtl/simpleuart_axi_pkg.sv | 40 ++++
 rtl/axi_simpleuart_bridge.sv | 177 +++++++++++++++++
 tb/tb_axi_simpleuart_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simpleuart_axi_pkg.sv
// Shared definitions for the AXI4-Lite to simpleuart register bridge:
// register offsets, AXI response codes, FSM states and the window decoder.
package simpleuart_axi_pkg;

  localparam logic [3:0] UART_DIV_OFF = 4'h0;
  localparam logic [3:0] UART_DAT_OFF = 4'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_RESP
  } bridge_state_t;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_DIV,
    TGT_DAT
  } target_t;

  // Byte lanes addr[1:0] never select a register; only the word offset does.
  function automatic target_t decode_target(input logic [31:0] addr,
                                            input logic [31:0] base);
    target_t tgt;
    tgt = TGT_NONE;
    if (addr[31:4] == base[31:4]) begin
      if ({addr[3:2], 2'b00} == UART_DIV_OFF) begin
        tgt = TGT_DIV;
      end else if ({addr[3:2], 2'b00} == UART_DAT_OFF) begin
        tgt = TGT_DAT;
      end
    end
    return tgt;
  endfunction

endpackage

// File: rtl/axi_simpleuart_bridge.sv
// AXI4-Lite slave driving the simpleuart divider/data register strobes,
// one transaction at a time, with a bounded wait on reg_dat_wait.
module axi_simpleuart_bridge
  import simpleuart_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,

  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,

  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,

  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,

  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,

  output logic [3:0]  reg_div_we,
  output logic [31:0] reg_div_di,
  input  logic [31:0] reg_div_do,

  output logic        reg_dat_we,
  output logic        reg_dat_re,
  output logic [31:0] reg_dat_di,
  input  logic [31:0] reg_dat_do,
  input  logic        reg_dat_wait
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  bridge_state_t    state;
  target_t          tgt;
  logic [CNT_W-1:0] wait_cnt;

  target_t wr_tgt;
  target_t rd_tgt;

  assign wr_tgt = decode_target(s_awaddr, BASE_ADDR);
  assign rd_tgt = decode_target(s_araddr, BASE_ADDR);

  // Readies are registered: a request seen in IDLE raises ready for exactly
  // one cycle, and the handshake on that cycle moves the FSM out of IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: every register here is state, so all assignments are non-blocking
    // and every one of them has a reset value; there is no memory array to skip.
    if (!resetn) begin
      state      <= IDLE;
      tgt        <= TGT_NONE;
      wait_cnt   <= '0;
      s_awready  <= 1'b0;
      s_wready   <= 1'b0;
      s_arready  <= 1'b0;
      s_bvalid   <= 1'b0;
      s_bresp    <= RESP_OKAY;
      s_rvalid   <= 1'b0;
      s_rresp    <= RESP_OKAY;
      s_rdata    <= '0;
      reg_div_we <= '0;
      reg_div_di <= '0;
      reg_dat_we <= 1'b0;
      reg_dat_re <= 1'b0;
      reg_dat_di <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_awready) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            tgt       <= wr_tgt;
            wait_cnt  <= '0;
            if (wr_tgt == TGT_DIV) begin
              reg_div_we <= s_wstrb;
              reg_div_di <= s_wdata;
            end else if (wr_tgt == TGT_DAT && s_wstrb[0]) begin
              reg_dat_we <= 1'b1;
              reg_dat_di <= s_wdata;
            end
            state <= WR_EXEC;
          end else if (s_arready) begin
            s_arready <= 1'b0;
            tgt       <= rd_tgt;
            if (rd_tgt == TGT_DAT) begin
              reg_dat_re <= 1'b1;
            end
            state <= RD_EXEC;
          end else if (s_awvalid && s_wvalid) begin
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end else if (s_arvalid) begin
            s_arready <= 1'b1;
          end
        end

        WR_EXEC: begin
          if (reg_dat_we) begin
            // simpleuart latches the byte on the first cycle wait is low.
            if (!reg_dat_wait) begin
              reg_dat_we <= 1'b0;
              wait_cnt   <= '0;
              s_bresp    <= RESP_OKAY;
              s_bvalid   <= 1'b1;
              state      <= WR_RESP;
            end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
              reg_dat_we <= 1'b0;
              wait_cnt   <= '0;
              s_bresp    <= RESP_SLVERR;
              s_bvalid   <= 1'b1;
              state      <= WR_RESP;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            reg_div_we <= '0;
            s_bresp    <= (tgt == TGT_NONE) ? RESP_SLVERR : RESP_OKAY;
            s_bvalid   <= 1'b1;
            state      <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end

        RD_EXEC: begin
          // reg_dat_re is high during this cycle only; reg_dat_do is valid now.
          reg_dat_re <= 1'b0;
          case (tgt)
            TGT_DIV: begin
              s_rdata <= reg_div_do;
              s_rresp <= RESP_OKAY;
            end
            TGT_DAT: begin
              s_rdata <= reg_dat_do;
              s_rresp <= RESP_OKAY;
            end
            default: begin
              s_rdata <= '0;
              s_rresp <= RESP_SLVERR;
            end
          endcase
          s_rvalid <= 1'b1;
          state    <= RD_RESP;
        end

        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_simpleuart_bridge.sv
// Directed bench for axi_simpleuart_bridge: transaction-level expectations
// from a small register model plus a per-cycle protocol monitor.
module tb_axi_simpleuart_bridge;
  import simpleuart_axi_pkg::*;

  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di, reg_div_do, reg_dat_di, reg_dat_do;
  logic        reg_dat_we, reg_dat_re, reg_dat_wait;

  axi_simpleuart_bridge #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Peripheral side: simpleuart divider register and a programmable busy time.
  logic [31:0] uart_div = '0;
  assign reg_div_do = uart_div;
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (reg_div_we[i]) uart_div[8*i +: 8] <= reg_div_di[8*i +: 8];

  int wait_cfg  = 0;
  int wait_used = 0;
  always @(negedge clk) begin
    if (!reg_dat_we) begin
      wait_used    <= 0;
      reg_dat_wait <= 1'b0;
    end else begin
      reg_dat_wait <= (wait_used < wait_cfg);
      wait_used    <= wait_used + 1;
    end
  end

  // Bench-side expectations derived from the register map rules.
  logic [31:0] exp_div    = '0;
  logic [31:0] exp_dat_di = '0;

  function automatic int region(input logic [31:0] a);  // 0 DIV, 1 DAT, 2 unmapped
    if (a[31:4] != BASE[31:4]) return 2;
    if (a[3:2] == 2'd0) return 0;
    if (a[3:2] == 2'd1) return 1;
    return 2;
  endfunction

  function automatic int exp_wr_lat(input int waits);
    return (waits >= TMO) ? TMO + 1 : waits + 2;
  endfunction

  function automatic int exp_we_len(input int waits);
    return (waits >= TMO) ? TMO : waits + 1;
  endfunction

  // Per-cycle monitor: response stability, single-cycle strobes, ready rules.
  logic        stall_b = 1'b0, stall_r = 1'b0, prev_re = 1'b0;
  logic [1:0]  held_bresp, held_rresp;
  logic [31:0] held_rdata;
  int          div_we_cycles = 0, dat_we_cycles = 0, dat_re_cycles = 0, ar_hs = 0;
  logic [3:0]  last_div_we = '0;
  logic [31:0] last_div_di = '0;

  always @(posedge clk) begin
    stall_b    <= s_bvalid && !s_bready;
    stall_r    <= s_rvalid && !s_rready;
    held_bresp <= s_bresp;
    held_rresp <= s_rresp;
    held_rdata <= s_rdata;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (stall_b) begin
        check("bvalid_held", s_bvalid, 1);
        check("bresp_stable", s_bresp, held_bresp);
      end
      if (stall_r) begin
        check("rvalid_held", s_rvalid, 1);
        check("rdata_stable", s_rdata, held_rdata);
        check("rresp_stable", s_rresp, held_rresp);
      end
      if (reg_dat_re) begin
        dat_re_cycles++;
        check("dat_re_single", prev_re, 0);
      end
      if (reg_div_we != 4'h0) begin
        div_we_cycles++;
        last_div_we = reg_div_we;
        last_div_di = reg_div_di;
      end
      if (reg_dat_we) begin
        dat_we_cycles++;
        check("dat_di", reg_dat_di, exp_dat_di);
      end
      if (s_awready || s_wready) check("aw_w_ready_pair", s_wready, s_awready);
      if (s_awready || s_arready) check("one_ready", s_awready && s_arready, 0);
      if (s_arready) ar_hs++;
    end
    prev_re = reg_dat_re;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit with_ar,
                           input logic [31:0] ar_addr,
                           output logic [1:0] resp, output int lat);
    int n;
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    if (with_ar) begin s_araddr = ar_addr; s_arvalid = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < 20);
    check("aw_accept", s_awready, 1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_bvalid && lat < 100);
    check("bvalid_seen", s_bvalid, 1);
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    check("bvalid_clear", s_bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready && n < 20);
    check("ar_accept", s_arready, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!s_rvalid && lat < 100);
    check("rvalid_seen", s_rvalid, 1);
    data = s_rdata;
    resp = s_rresp;
    repeat (stall) @(negedge clk);
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    @(negedge clk);
    check("rvalid_clear", s_rvalid, 0);
  endtask

  // Full transaction with all expectations computed from the address map.
  task automatic run_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int waits, input bit with_ar,
                           output logic [1:0] resp, output int lat);
    int r, div0, dat0, ar0;
    logic [1:0] eresp;
    r = region(addr);
    wait_cfg = waits;
    exp_dat_di = data;
    div0 = div_we_cycles; dat0 = dat_we_cycles; ar0 = ar_hs;
    axi_write(addr, data, strb, with_ar, addr, resp, lat);
    if (r == 2) eresp = RESP_SLVERR;
    else if (r == 1 && strb[0] && waits >= TMO) eresp = RESP_SLVERR;
    else eresp = RESP_OKAY;
    check({name, "_bresp"}, resp, eresp);
    check({name, "_div_we_n"}, div_we_cycles - div0, (r == 0 && strb != 0) ? 1 : 0);
    check({name, "_dat_we_n"}, dat_we_cycles - dat0, (r == 1 && strb[0]) ? exp_we_len(waits) : 0);
    if (r != 2) check({name, "_lat"}, lat, (r == 1 && strb[0]) ? exp_wr_lat(waits) : 2);
    if (r == 0 && strb != 0) begin
      check({name, "_div_we"}, last_div_we, strb);
      check({name, "_div_di"}, last_div_di, data);
      for (int i = 0; i < 4; i++) if (strb[i]) exp_div[8*i +: 8] = data[8*i +: 8];
    end
    if (with_ar) check({name, "_ar_waits"}, ar_hs - ar0, 0);
    wait_cfg = 0;
  endtask

  task automatic run_read(input string name, input logic [31:0] addr, input int stall,
                          output logic [31:0] data);
    int r, re0, lat;
    logic [1:0] resp;
    r = region(addr);
    re0 = dat_re_cycles;
    axi_read(addr, stall, data, resp, lat);
    check({name, "_rresp"}, resp, (r == 2) ? RESP_SLVERR : RESP_OKAY);
    check({name, "_rdata"}, data, (r == 0) ? exp_div : (r == 1) ? reg_dat_do : 32'h0);
    check({name, "_re_n"}, dat_re_cycles - re0, (r == 1) ? 1 : 0);
    check({name, "_lat"}, lat, 2);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat, n;

    resetn = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b0; s_rready = 1'b0;
    reg_dat_do = 32'h0;

    repeat (10) @(negedge clk);
    check("rst_ready_valid", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
    check("rst_resp_data", {s_bresp, s_rresp}, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_strobes", {reg_div_we, reg_dat_we, reg_dat_re}, 0);
    check("rst_div_di", reg_div_di, 0);
    check("rst_dat_di", reg_dat_di, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                               reg_div_we, reg_dat_we, reg_dat_re}, 0);

    // Divider write then read-back; literals pin the model.
    run_write("div_wr", BASE, 32'h0000_0068, 4'hF, 0, 1'b0, resp, lat);
    check("div_wr_okay_lit", resp, 2'b00);
    check("div_wr_lat_lit", lat, 2);
    check("div_we_lit", last_div_we, 4'hF);
    check("div_di_lit", last_div_di, 32'h68);
    run_read("div_rd", BASE, 0, data);
    check("div_rd_lit", data, 32'h68);

    run_write("div_part", BASE, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, resp, lat);
    run_read("div_part_rd", BASE + 32'h3, 0, data);
    check("div_part_lit", data, 32'h00BB_00DD);

    // Data register writes: back-pressure, no wait, no strobe lane, timeout.
    run_write("dat_wait5", BASE + 32'h4, 32'h41, 4'h1, 5, 1'b0, resp, lat);
    check("dat_wait5_lat_lit", lat, 7);
    run_write("dat_nowait", BASE + 32'h4, 32'h42, 4'hF, 0, 1'b0, resp, lat);
    check("dat_nowait_lat_lit", lat, 2);
    run_write("dat_nolane", BASE + 32'h4, 32'h99, 4'b1110, 0, 1'b0, resp, lat);
    run_write("dat_tmo", BASE + 32'h4, 32'h43, 4'h1, 1000, 1'b0, resp, lat);
    check("dat_tmo_slverr_lit", resp, 2'b10);
    check("dat_tmo_lat_lit", lat, 17);

    // Data register reads, including the "no byte" pattern.
    reg_dat_do = 32'h0000_005A;
    run_read("dat_rd", BASE + 32'h4, 0, data);
    check("dat_rd_lit", data, 32'h5A);
    reg_dat_do = 32'hFFFF_FFFF;
    run_read("dat_rd_empty", BASE + 32'h4, 0, data);
    check("dat_rd_empty_lit", data, 32'hFFFF_FFFF);

    // Unmapped offsets and windows.
    run_write("unmap_wr8", BASE + 32'h8, 32'h1234_5678, 4'hF, 0, 1'b0, resp, lat);
    run_write("unmap_wrwin", 32'h0300_0000, 32'h1, 4'hF, 0, 1'b0, resp, lat);
    run_read("unmap_rdwin", 32'h0300_0000, 0, data);
    run_read("unmap_rdC", BASE + 32'hC, 0, data);
    check("unmap_rd_lit", data, 32'h0);

    // Concurrent AW/W/AR: write wins, then the read sees its effect.
    run_write("both_wr", BASE, 32'h0000_1234, 4'hF, 0, 1'b1, resp, lat);
    run_read("both_rd", BASE, 4, data);
    check("both_rd_lit", data, 32'h1234);

    // Reset during a stalled data write.
    wait_cfg = 1000;
    exp_dat_di = 32'h44;
    @(posedge clk); #1;
    s_awaddr = BASE + 32'h4; s_wdata = 32'h44; s_wstrb = 4'h1;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < 20);
    check("mid_rst_aw_accept", s_awready, 1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_we_before", reg_dat_we, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_we_drop", reg_dat_we, 0);
    check("mid_rst_no_bvalid", s_bvalid, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_bvalid_low", s_bvalid, 0);
    end
    resetn = 1'b1;
    wait_cfg = 0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_late_b", {s_bvalid, reg_dat_we}, 0);
    run_read("after_rst_rd", BASE, 0, data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
